// File: rtl/ws2812_pkg.sv
// WS2812 port controller shared definitions.
// Port offsets, status layout and FSM encoding.
package ws2812_pkg;

  localparam logic [1:0] WS_PORT_IDX    = 2'd0;
  localparam logic [1:0] WS_PORT_DATA   = 2'd1;
  localparam logic [1:0] WS_PORT_COUNT  = 2'd2;
  localparam logic [1:0] WS_PORT_STATUS = 2'd3;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_DIRTY_BIT = 1;
  localparam int ST_OVF_BIT   = 2;

  localparam int BYTES_PER_LED = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_PF_ADDR,
    ST_PF_WAIT
  } ws_state_e;

  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
  } ws_req_t;

endpackage

// File: rtl/ws2812_port_ctrl_if.sv
// Z80 I/O decoder side of the WS2812 port block.
// master = CPU decoder, slave = port controller.
interface ws2812_port_ctrl_if;

  logic       io_req;
  logic       io_wr;
  logic [1:0] io_addr;
  logic [7:0] io_data_in;
  logic [7:0] io_data_out;

  modport master (
    output io_req,
    output io_wr,
    output io_addr,
    output io_data_in,
    input  io_data_out
  );

  modport slave (
    input  io_req,
    input  io_wr,
    input  io_addr,
    input  io_data_in,
    output io_data_out
  );

endinterface

// File: rtl/ws2812_refresh_sched.sv
// Refresh scheduler: holdoff after the last buffer write,
// then one tx_start pulse once the serializer is free.
module ws2812_refresh_sched #(
  parameter int HOLDOFF = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic kick_i,
  input  logic tx_busy_i,
  output logic tx_start_o,
  output logic dirty_o
);

  localparam int CW = $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLDOFF);

  logic [CW-1:0] cnt_q;
  logic          dirty_q;
  logic          tx_start_q;
  logic          fire;

  // a write landing on the firing cycle wins and restarts the holdoff
  assign fire = dirty_q && (cnt_q == '0)
             && !tx_busy_i && !kick_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      dirty_q    <= 1'b0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= fire;
      if (kick_i) begin
        dirty_q <= 1'b1;
        cnt_q   <= RELOAD;
      end else begin
        if (cnt_q != '0)
          cnt_q <= cnt_q - 1'b1;
        if (fire)
          dirty_q <= 1'b0;
      end
    end
  end

  assign tx_start_o = tx_start_q;
  assign dirty_o    = dirty_q;

endmodule

// File: rtl/ws2812_port_ctrl.sv
// WS2812 port block: Z80 ports $30-$33 onto the RGB buffer RAM,
// LED pointer with auto-increment, read prefetch, refresh scheduling.
module ws2812_port_ctrl
  import ws2812_pkg::*;
#(
  parameter int LED_AW  = 8,
  parameter int HOLDOFF = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  ws2812_port_ctrl_if.slave io,
  output logic [LED_AW+1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [LED_AW:0]   led_count,
  output logic              tx_start,
  input  logic              tx_busy
);

  localparam int MAX_LEDS = 1 << LED_AW;
  localparam logic [LED_AW:0] MAX_CNT =
    {1'b1, {LED_AW{1'b0}}};
  localparam logic [1:0] BSEL_LAST =
    2'(BYTES_PER_LED - 1);

  ws_state_e         state_q;
  logic [LED_AW-1:0] idx_q;
  logic [1:0]        bsel_q;
  logic [7:0]        pf_q;
  logic              ovf_q;
  ws_req_t           pend_q;
  logic              pend_vld_q;
  logic [LED_AW:0]   cnt_q;
  logic [LED_AW+1:0] ram_addr_q;
  logic              ram_we_q;
  logic [7:0]        ram_wdata_q;
  logic [7:0]        dout_q;

  ws_req_t           req_in;
  ws_req_t           cur;
  logic              go;
  logic              d_wr_idx;
  logic              d_wr_data;
  logic              d_rd_data;
  logic              d_wr_cnt;
  logic              d_wr_stat;
  logic              kick;
  logic              dirty;
  logic              last_led;
  logic              clamp;
  logic [LED_AW-1:0] adv_idx;
  logic [1:0]        adv_bsel;
  logic [LED_AW-1:0] wr_idx;
  logic [LED_AW:0]   new_cnt;
  logic [LED_AW-1:0] cnt_idx;
  logic [1:0]        cnt_bsel;
  logic [7:0]        status;
  logic [7:0]        dout_d;

  assign req_in = {io.io_wr, io.io_addr, io.io_data_in};

  always_comb begin
    cur = pend_vld_q ? pend_q : req_in;
    go  = (state_q == ST_IDLE)
       && (pend_vld_q || io.io_req);

    d_wr_idx  = go && cur.wr
             && (cur.addr == WS_PORT_IDX);
    d_wr_data = go && cur.wr
             && (cur.addr == WS_PORT_DATA);
    d_rd_data = go && !cur.wr
             && (cur.addr == WS_PORT_DATA);
    d_wr_cnt  = go && cur.wr
             && (cur.addr == WS_PORT_COUNT);
    d_wr_stat = go && cur.wr
             && (cur.addr == WS_PORT_STATUS);
    kick      = d_wr_data || d_wr_cnt;

    last_led = ({1'b0, idx_q} == (cnt_q - 1'b1));
    if (bsel_q == BSEL_LAST) begin
      adv_bsel = '0;
      adv_idx  = last_led ? '0 : idx_q + 1'b1;
    end else begin
      adv_bsel = bsel_q + 1'b1;
      adv_idx  = idx_q;
    end

    if (int'(cur.data) >= int'(cnt_q))
      wr_idx = '0;
    else
      wr_idx = LED_AW'(cur.data);

    // 0 selects the full strip; larger values saturate
    if (cur.data == 8'd0 || int'(cur.data) >= MAX_LEDS)
      new_cnt = MAX_CNT;
    else
      new_cnt = (LED_AW+1)'(cur.data);

    clamp    = int'(idx_q) >= int'(new_cnt);
    cnt_idx  = clamp ? '0 : idx_q;
    cnt_bsel = clamp ? '0 : bsel_q;

    status               = '0;
    status[ST_OVF_BIT]   = ovf_q;
    status[ST_DIRTY_BIT] = dirty;
    status[ST_BUSY_BIT]  = tx_busy;

    dout_d = '0;
    unique case (io.io_addr)
      WS_PORT_IDX:    dout_d = 8'(idx_q);
      WS_PORT_DATA:   dout_d = pf_q;
      WS_PORT_COUNT:  dout_d = 8'(cnt_q);
      WS_PORT_STATUS: dout_d = status;
      default:        dout_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      bsel_q      <= '0;
      pf_q        <= '0;
      ovf_q       <= 1'b0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      cnt_q       <= MAX_CNT;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      dout_q      <= '0;
    end else begin
      dout_q <= dout_d;

      unique case (state_q)
        ST_IDLE: begin
          // address is set up on entry to PF_ADDR so
          // rdata is ready by the end of PF_WAIT
          unique case (1'b1)
            d_wr_idx: begin
              idx_q      <= wr_idx;
              bsel_q     <= '0;
              ram_addr_q <= {wr_idx, 2'b00};
              state_q    <= ST_PF_ADDR;
            end
            d_wr_data: begin
              ram_addr_q  <= {idx_q, bsel_q};
              ram_we_q    <= 1'b1;
              ram_wdata_q <= cur.data;
              idx_q       <= adv_idx;
              bsel_q      <= adv_bsel;
              state_q     <= ST_WRITE;
            end
            d_rd_data: begin
              idx_q      <= adv_idx;
              bsel_q     <= adv_bsel;
              ram_addr_q <= {adv_idx, adv_bsel};
              state_q    <= ST_PF_ADDR;
            end
            d_wr_cnt: begin
              cnt_q      <= new_cnt;
              idx_q      <= cnt_idx;
              bsel_q     <= cnt_bsel;
              ram_addr_q <= {cnt_idx, cnt_bsel};
              state_q    <= ST_PF_ADDR;
            end
            d_wr_stat: begin
              if (cur.data[ST_OVF_BIT])
                ovf_q <= 1'b0;
            end
            default: ;
          endcase
        end
        ST_WRITE: begin
          ram_we_q   <= 1'b0;
          ram_addr_q <= {idx_q, bsel_q};
          state_q    <= ST_PF_ADDR;
        end
        ST_PF_ADDR: state_q <= ST_PF_WAIT;
        ST_PF_WAIT: begin
          pf_q    <= ram_rdata;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      // one-deep skid for requests arriving while busy
      if (io.io_req
          && (state_q != ST_IDLE || pend_vld_q)) begin
        if (state_q != ST_IDLE && pend_vld_q) begin
          ovf_q <= 1'b1;
        end else begin
          pend_q     <= req_in;
          pend_vld_q <= 1'b1;
        end
      end else if (state_q == ST_IDLE && pend_vld_q) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

  ws2812_refresh_sched #(
    .HOLDOFF (HOLDOFF)
  ) u_sched (
    .clk        (clk),
    .reset_n    (reset_n),
    .kick_i     (kick),
    .tx_busy_i  (tx_busy),
    .tx_start_o (tx_start),
    .dirty_o    (dirty)
  );

  assign io.io_data_out = dout_q;
  assign ram_addr       = ram_addr_q;
  assign ram_we         = ram_we_q;
  assign ram_wdata      = ram_wdata_q;
  assign led_count      = cnt_q;

endmodule
